// File: rtl/fixed_dot_product_acc.sv
// Streaming signed fixed-point dot product with cross-beat accumulation.
// Three-stage pipeline: operand register, lane product sum, accumulate + floor/saturate.
module fixed_dot_product_acc #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int LANES = 8,
    parameter int GUARD = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_in_valid,
    output logic                     io_in_ready,
    input  logic                     io_in_last,
    input  logic [LANES*WIDTH-1:0]   io_a,
    input  logic [LANES*WIDTH-1:0]   io_b,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [WIDTH-1:0]         io_c,
    output logic                     io_sat
);

    localparam int ACC_W  = 2*WIDTH + $clog2(LANES) + GUARD;
    localparam int PROD_W = 2*WIDTH;

    // Arithmetic shift right by FRAC: rounds toward negative infinity.
    function automatic logic signed [ACC_W-1:0] floor_shift(input logic signed [ACC_W-1:0] s);
        return s >>> FRAC;
    endfunction

    // Returns {sat, value}; clips whenever the bits above the result sign are not a pure sign extension.
    function automatic logic [WIDTH:0] saturate(input logic signed [ACC_W-1:0] r);
        logic [ACC_W-WIDTH:0] top;
        top = r[ACC_W-1:WIDTH-1];
        if (top == '0 || top == '1)
            return {1'b0, r[WIDTH-1:0]};
        else if (r[ACC_W-1])
            return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    logic                     en;
    logic                     vld_p1;
    logic                     last_p1;
    logic [LANES*WIDTH-1:0]   a_p1;
    logic [LANES*WIDTH-1:0]   b_p1;
    logic signed [PROD_W-1:0] prod_p1 [LANES];
    logic signed [ACC_W-1:0]  sum_p1;
    logic                     vld_p2;
    logic                     last_p2;
    logic signed [ACC_W-1:0]  sum_p2;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum_p2;
    logic [WIDTH:0]           res_p2;

    // The whole pipeline freezes only while a result is held and refused.
    assign en          = !(io_out_valid && !io_out_ready);
    assign io_in_ready = en;

    // ---- Stage 1: operand capture ----
    always_ff @(posedge clk) begin
        if (reset)
            vld_p1 <= 1'b0;
        else if (en)
            vld_p1 <= io_in_valid;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            a_p1    <= io_a;
            b_p1    <= io_b;
            last_p1 <= io_in_last;
        end
    end

    // ---- Stage 2: lane products, sign-extended and summed ----
    always_comb begin
        sum_p1 = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_p1[i] = PROD_W'($signed(a_p1[i*WIDTH +: WIDTH])) *
                         PROD_W'($signed(b_p1[i*WIDTH +: WIDTH]));
            sum_p1     = sum_p1 + ACC_W'(prod_p1[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            vld_p2 <= 1'b0;
        else if (en)
            vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            sum_p2  <= sum_p1;
            last_p2 <= last_p1;
        end
    end

    // ---- Stage 3: accumulate, then floor/saturate on the last beat ----
    assign acc_sum_p2 = acc + sum_p2;
    assign res_p2     = saturate(floor_shift(acc_sum_p2));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc          <= '0;
            io_out_valid <= 1'b0;
            io_c         <= '0;
            io_sat       <= 1'b0;
        end else if (en) begin
            if (vld_p2 && last_p2) begin
                acc          <= '0;
                io_c         <= res_p2[WIDTH-1:0];
                io_sat       <= res_p2[WIDTH];
                io_out_valid <= 1'b1;
            end else begin
                if (vld_p2)
                    acc <= acc_sum_p2;
                // With en high any held result is being consumed this edge.
                io_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_dot_product_acc.sv
// Randomized bench for fixed_dot_product_acc against a wide-integer reference model.
module tb_fixed_dot_product_acc;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;
    localparam int LANES = 8;
    localparam int GUARD = 8;
    localparam int ACC_W = 2*WIDTH + $clog2(LANES) + GUARD;
    localparam int VW    = LANES*WIDTH;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             io_in_valid = 1'b0;
    logic             io_in_ready;
    logic             io_in_last = 1'b0;
    logic [VW-1:0]    io_a = '0;
    logic [VW-1:0]    io_b = '0;
    logic             io_out_valid;
    logic             io_out_ready = 1'b1;
    logic [WIDTH-1:0] io_c;
    logic             io_sat;

    fixed_dot_product_acc #(.WIDTH(WIDTH), .FRAC(FRAC), .LANES(LANES), .GUARD(GUARD)) dut (
        .clk(clk), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_last(io_in_last),
        .io_a(io_a), .io_b(io_b),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_c(io_c), .io_sat(io_sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int rdy_mode = 0;
    int bp_base = 0;
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] e;
    logic signed [127:0] m_acc = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [VW-1:0] fill(input logic [WIDTH-1:0] x);
        return {LANES{x}};
    endfunction

    function automatic logic [VW-1:0] lane0(input logic [WIDTH-1:0] x);
        return VW'(x);
    endfunction

    // Lanes uniformly spread over [-2^half, 2^half).
    function automatic logic [VW-1:0] rand_vec(input int half);
        logic [VW-1:0] v;
        logic signed [WIDTH-1:0] t;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            t = $signed($urandom);
            t = t >>> (WIDTH-1-half);
            v[i*WIDTH +: WIDTH] = t;
        end
        return v;
    endfunction

    function automatic logic signed [127:0] beat_sum(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic signed [127:0] s, pa, pb;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            pa = $signed(a[i*WIDTH +: WIDTH]);
            pb = $signed(b[i*WIDTH +: WIDTH]);
            s  = s + pa*pb;
        end
        return s;
    endfunction

    // Exact vector sum -> wrap to ACC_W -> floor by 2^FRAC -> clip to WIDTH. Returns {sat, c}.
    function automatic logic [WIDTH:0] model_result(input logic signed [127:0] acc);
        logic signed [127:0] w, r, maxv, minv;
        w = acc <<< (128-ACC_W);
        w = w >>> (128-ACC_W);
        r = w >>> FRAC;
        maxv = (128'sd1 <<< (WIDTH-1)) - 128'sd1;
        minv = -(128'sd1 <<< (WIDTH-1));
        if (r > maxv) return {1'b1, maxv[WIDTH-1:0]};
        if (r < minv) return {1'b1, minv[WIDTH-1:0]};
        return {1'b0, r[WIDTH-1:0]};
    endfunction

    task automatic model_accept(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic last);
        m_acc = m_acc + beat_sum(a, b);
        if (last) begin
            exp_q.push_back(model_result(m_acc));
            m_acc = '0;
        end
    endtask

    // Advance one cycle; inputs default to a bubble carrying junk data.
    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        io_in_valid = 1'b0;
        io_in_last  = 1'($urandom_range(0, 1));
        io_a        = rand_vec(31);
        io_b        = rand_vec(31);
        case (rdy_mode)
            0:       io_out_ready = 1'b1;
            1:       io_out_ready = ($urandom_range(0, 9) < 7);
            default: io_out_ready = !((cycle - bp_base) >= 4 && (cycle - bp_base) <= 8);
        endcase
        #1;
    endtask

    task automatic send_beat(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic last);
        int waited = 0;
        io_in_valid = 1'b1; io_a = a; io_b = b; io_in_last = last;
        while (!io_in_ready) begin
            if (waited > 200) begin
                checks++; failures++;
                $display("FAIL accept_timeout actual=no_ready required=ready_within_200");
                io_in_valid = 1'b0;
                return;
            end
            waited++;
            step();
            io_in_valid = 1'b1; io_a = a; io_b = b; io_in_last = last;
        end
        model_accept(a, b, last);
        step();
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 0;
        while ((exp_q.size() != 0 || io_out_valid) && n < 100) begin
            step();
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 0);
    endtask

    task automatic directed(input string name, input int n, input logic [VW-1:0] a,
                            input logic [VW-1:0] b, input logic [WIDTH-1:0] ec, input logic es);
        drain();
        for (int k = 0; k < n; k++) send_beat(a, b, k == n-1);
        check({name, "_valid_t1"}, 64'(io_out_valid), 0);
        step();
        check({name, "_valid_t2"}, 64'(io_out_valid), 0);
        step();
        check({name, "_valid_t3"}, 64'(io_out_valid), 1);
        check({name, "_c"}, 64'(io_c), 64'(ec));
        check({name, "_sat"}, 64'(io_sat), 64'(es));
    endtask

    // Every cycle: ready rule, and each consumed result against the model in order.
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", 64'(io_in_ready), 64'(!(io_out_valid && !io_out_ready)));
            if (io_out_valid && io_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_result actual=%0h required=none", {io_sat, io_c});
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'({io_sat, io_c}), 64'(e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Model pinned to hand-computed values.
        check("pin_single", 64'(model_result(beat_sum(fill(32'h00010000), fill(32'h00020000)))), 64'({1'b0, 32'h00100000}));
        check("pin_three", 64'(model_result(3 * beat_sum(fill(32'h00010000), fill(32'hFFFF8000)))), 64'({1'b0, 32'hFFF40000}));
        check("pin_satpos", 64'(model_result(beat_sum(fill(32'h7FFFFFFF), fill(32'h7FFFFFFF)))), 64'({1'b1, 32'h7FFFFFFF}));
        check("pin_floor", 64'(model_result(beat_sum(lane0(32'hFFFFFFFF), lane0(32'h00008000)))), 64'({1'b0, 32'hFFFFFFFF}));
        check("pin_k7", 64'(model_result(beat_sum(lane0(32'h00070000), lane0(32'h00010000)))), 64'({1'b0, 32'h00070000}));

        repeat (3) step();
        reset = 1'b0;
        check("rst_out_valid", 64'(io_out_valid), 0);
        check("rst_c", 64'(io_c), 0);
        check("rst_sat", 64'(io_sat), 0);
        check("rst_in_ready", 64'(io_in_ready), 1);

        directed("single", 1, fill(32'h00010000), fill(32'h00020000), 32'h00100000, 1'b0);
        directed("three", 3, fill(32'h00010000), fill(32'hFFFF8000), 32'hFFF40000, 1'b0);
        directed("satpos", 1, fill(32'h7FFFFFFF), fill(32'h7FFFFFFF), 32'h7FFFFFFF, 1'b1);
        directed("satneg", 1, fill(32'h80000000), fill(32'h7FFFFFFF), 32'h80000000, 1'b1);
        directed("floor", 1, lane0(32'hFFFFFFFF), lane0(32'h00008000), 32'hFFFFFFFF, 1'b0);

        // Backpressure window while ten single-beat vectors stream.
        drain();
        bp_base  = cycle;
        rdy_mode = 2;
        for (int k = 1; k <= 10; k++)
            send_beat(lane0(WIDTH'(k) << FRAC), lane0(32'h00010000), 1'b1);
        drain();

        // Reset mid-vector discards the partial sum and in-flight beats.
        drain();
        send_beat(fill(32'h00010000), fill(32'h00010000), 1'b0);
        send_beat(fill(32'h00010000), fill(32'h00010000), 1'b0);
        reset = 1'b1;
        m_acc = '0;
        step();
        reset = 1'b0;
        check("midrst_out_valid", 64'(io_out_valid), 0);
        check("midrst_c", 64'(io_c), 0);
        check("midrst_sat", 64'(io_sat), 0);
        check("midrst_in_ready", 64'(io_in_ready), 1);
        directed("after_reset", 1, fill(32'h00010000), fill(32'h00010000), 32'h00080000, 1'b0);

        // Random vectors with bubbles and random consumer stalls.
        drain();
        rdy_mode = 1;
        for (int v = 0; v < 250; v++) begin
            int nb;
            int half;
            nb = $urandom_range(1, 4);
            case ($urandom_range(0, 3))
                0: half = 12;
                1: half = 19;
                2: half = 23;
                default: half = 31;
            endcase
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 3) == 0) step();
                send_beat(rand_vec(half), rand_vec(half), k == nb-1);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
